adc16dv160_capture_ctrl: RTL and testbench

- Sequences one ADC capture: takes packed sample words from the ADC-to-ACLK CDC FIFO and emits exactly dsize beats on the AXI-Stream master, with tlast on the final beat.
- Sits between adc16dv160_input_data_receiver's FIFO read side and the m00_axis port. Configured by the control/status register bits (cr_start, cr_test, dsize, trigger mode) and reports sr_pc, busy and overflow back to the register file.

---
 rtl/adc16dv160_capture_ctrl_if.sv | 50 +++++
 rtl/adc16dv160_capture_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_adc16dv160_capture_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc16dv160_capture_ctrl_if.sv
// ---------------------------------------------------------------------------
// adc16dv160_capture_ctrl_if
// Groups the FIFO read side and the AXI-Stream master side of the capture
// controller into one bundle.
//   master : the capture controller (pops the FIFO, drives the stream)
//   slave  : the environment (FIFO model / stream sink)
// Signals:
//   fifo_dout     FWFT FIFO head word, {sample_n+1, sample_n}
//   fifo_valid    FIFO not empty
//   fifo_full     FIFO write side overflowing
//   fifo_rd_en    pop strobe
//   m_axis_*      AXI-Stream master beat (tdata/tkeep/tvalid/tlast/tready)
// ---------------------------------------------------------------------------
interface adc16dv160_capture_ctrl_if #(
  parameter int SAMPLE_W = 16
);
  logic [2*SAMPLE_W-1:0] fifo_dout;
  logic                  fifo_valid;
  logic                  fifo_full;
  logic                  fifo_rd_en;
  logic [2*SAMPLE_W-1:0] m_axis_tdata;
  logic [3:0]            m_axis_tkeep;
  logic                  m_axis_tvalid;
  logic                  m_axis_tlast;
  logic                  m_axis_tready;

  modport master (
    input  fifo_dout,
    input  fifo_valid,
    input  fifo_full,
    output fifo_rd_en,
    output m_axis_tdata,
    output m_axis_tkeep,
    output m_axis_tvalid,
    output m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    output fifo_dout,
    output fifo_valid,
    output fifo_full,
    input  fifo_rd_en,
    input  m_axis_tdata,
    input  m_axis_tkeep,
    input  m_axis_tvalid,
    input  m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/adc16dv160_capture_ctrl.sv
// ---------------------------------------------------------------------------
// adc16dv160_capture_ctrl
// Sequences one ADC capture: pops packed sample words from the CDC FIFO (or
// generates a ramp in test mode) and emits exactly dsize beats on the
// AXI-Stream master, with tlast on the final beat.
// Ports:
//   ACLK, ARESETN   stream clock, asynchronous active-low reset
//   start, abort    one-cycle command pulses (abort wins over start)
//   test            ramp pattern instead of FIFO data (sampled on start)
//   trig_mode       0 = capture immediately, 1 = wait for trig_in rising edge
//   trig_in         external trigger, synchronous to ACLK
//   dsize           beats per capture (sampled on start)
//   bus             FIFO read side + AXI-Stream master (master modport)
//   busy            capture in progress (WAIT_TRIG/CAPTURE/DRAIN)
//   sr_pc           packet complete, sticky until next start
//   overflow        fifo_full seen during CAPTURE, sticky until next start
//   beats_sent      beats accepted in the current/last capture
// ---------------------------------------------------------------------------
module adc16dv160_capture_ctrl #(
  parameter int CNT_W    = 32,
  parameter int SAMPLE_W = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      test,
  input  logic                      trig_mode,
  input  logic                      trig_in,
  input  logic [CNT_W-1:0]          dsize,
  adc16dv160_capture_ctrl_if.master bus,
  output logic                      busy,
  output logic                      sr_pc,
  output logic                      overflow,
  output logic [CNT_W-1:0]          beats_sent
);

  localparam int DATA_W = 2 * SAMPLE_W;
  localparam logic [CNT_W-1:0]    CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [SAMPLE_W-1:0] TCNT_ZERO = {SAMPLE_W{1'b0}};
  localparam logic [SAMPLE_W-1:0] TCNT_ONE  = {{(SAMPLE_W-1){1'b0}}, 1'b1};
  localparam logic [SAMPLE_W-1:0] TCNT_TWO  = {{(SAMPLE_W-2){1'b0}}, 2'b10};

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TRIG = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  state_t              state_r;
  state_t              state_s;

  logic [CNT_W-1:0]    remaining_r;
  logic [CNT_W-1:0]    beats_r;
  logic [SAMPLE_W-1:0] tcnt_r;
  logic                test_r;
  logic                trig_prev_r;
  logic                busy_r;
  logic                sr_pc_r;
  logic                overflow_r;
  logic [DATA_W-1:0]   tdata_r;
  logic                tvalid_r;
  logic                tlast_r;

  logic                hs_s;
  logic                src_ok_s;
  logic [DATA_W-1:0]   source_s;
  logic                load_s;
  logic                rd_en_s;
  logic                arm_s;
  logic                hold_last_s;
  logic                pc_set_s;

  assign hs_s     = tvalid_r & bus.m_axis_tready;
  // The ramp source never stalls; the FIFO source needs a word at its head.
  assign src_ok_s = test_r ? 1'b1 : bus.fifo_valid;
  assign source_s = test_r ? {tcnt_r + TCNT_ONE, tcnt_r} : bus.fifo_dout;

  // State register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_s     = state_r;
    load_s      = 1'b0;
    rd_en_s     = 1'b0;
    arm_s       = 1'b0;
    hold_last_s = 1'b0;
    pc_set_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        // Keep the FIFO empty between captures so stale samples never leak out.
        rd_en_s = bus.fifo_valid;
        if (start && !abort) begin
          arm_s = 1'b1;
          if (dsize == CNT_ZERO) begin
            state_s  = ST_DONE;
            pc_set_s = 1'b1;
          end else if (trig_mode) begin
            state_s = ST_WAIT_TRIG;
          end else begin
            state_s = ST_CAPTURE;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_WAIT_TRIG: begin
        rd_en_s = bus.fifo_valid;
        if (abort) begin
          state_s = ST_IDLE;
        end else if (trig_in && !trig_prev_r) begin
          state_s = ST_CAPTURE;
        end else begin
          state_s = ST_WAIT_TRIG;
        end
      end
      ST_CAPTURE: begin
        if (abort) begin
          rd_en_s = test_r ? bus.fifo_valid : 1'b0;
          // A presented beat must stay put until accepted; mark it last and drain.
          if (tvalid_r && !hs_s) begin
            hold_last_s = 1'b1;
            state_s     = ST_DRAIN;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          load_s  = (!tvalid_r || bus.m_axis_tready) && (remaining_r != CNT_ZERO) && src_ok_s;
          rd_en_s = test_r ? bus.fifo_valid : load_s;
          if (hs_s && tlast_r) begin
            state_s  = ST_DONE;
            pc_set_s = 1'b1;
          end else begin
            state_s = ST_CAPTURE;
          end
        end
      end
      ST_DRAIN: begin
        if (hs_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Capture bookkeeping: counters, latched config, sticky status flags.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      remaining_r <= CNT_ZERO;
      beats_r     <= CNT_ZERO;
      tcnt_r      <= TCNT_ZERO;
      test_r      <= 1'b0;
      trig_prev_r <= 1'b0;
      busy_r      <= 1'b0;
      sr_pc_r     <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      trig_prev_r <= trig_in;
      busy_r      <= (state_s == ST_WAIT_TRIG) || (state_s == ST_CAPTURE) || (state_s == ST_DRAIN);
      if (arm_s) begin
        remaining_r <= dsize;
        test_r      <= test;
        tcnt_r      <= TCNT_ZERO;
        beats_r     <= CNT_ZERO;
        overflow_r  <= 1'b0;
        sr_pc_r     <= pc_set_s;
      end else begin
        if (load_s) begin
          remaining_r <= remaining_r - CNT_ONE;
          if (test_r) begin
            tcnt_r <= tcnt_r + TCNT_TWO;
          end
        end
        if (hs_s) begin
          beats_r <= beats_r + CNT_ONE;
        end
        if ((state_r == ST_CAPTURE) && bus.fifo_full) begin
          overflow_r <= 1'b1;
        end
        if (pc_set_s) begin
          sr_pc_r <= 1'b1;
        end
      end
    end
  end

  // Single registered AXI-Stream output stage.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      tdata_r  <= {DATA_W{1'b0}};
      tvalid_r <= 1'b0;
      tlast_r  <= 1'b0;
    end else if (load_s) begin
      tdata_r  <= source_s;
      tvalid_r <= 1'b1;
      tlast_r  <= (remaining_r == CNT_ONE);
    end else if (hold_last_s) begin
      tlast_r  <= 1'b1;
    end else if (hs_s) begin
      tvalid_r <= 1'b0;
      tlast_r  <= 1'b0;
    end
  end

  assign bus.fifo_rd_en    = rd_en_s;
  assign bus.m_axis_tdata  = tdata_r;
  assign bus.m_axis_tkeep  = 4'hF;
  assign bus.m_axis_tvalid = tvalid_r;
  assign bus.m_axis_tlast  = tlast_r;
  assign busy              = busy_r;
  assign sr_pc             = sr_pc_r;
  assign overflow          = overflow_r;
  assign beats_sent        = beats_r;

endmodule

// File: tb/tb_adc16dv160_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adc16dv160_capture_ctrl
// Self-checking bench: a queue-based FWFT FIFO model feeds the controller,
// and a scoreboard predicts every accepted beat from the pushed words (normal
// mode) or from the ramp formula (test mode).
// ---------------------------------------------------------------------------
module tb_adc16dv160_capture_ctrl;
  localparam int CNT_W    = 32;
  localparam int SAMPLE_W = 16;

  logic             ACLK;
  logic             ARESETN;
  logic             start;
  logic             abort;
  logic             test;
  logic             trig_mode;
  logic             trig_in;
  logic [CNT_W-1:0] dsize;
  logic             busy;
  logic             sr_pc;
  logic             overflow;
  logic [CNT_W-1:0] beats_sent;

  int n_total;
  int n_bad;

  adc16dv160_capture_ctrl_if #(.SAMPLE_W(SAMPLE_W)) bus ();

  adc16dv160_capture_ctrl #(.CNT_W(CNT_W), .SAMPLE_W(SAMPLE_W)) dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .start      (start),
    .abort      (abort),
    .test       (test),
    .trig_mode  (trig_mode),
    .trig_in    (trig_in),
    .dsize      (dsize),
    .bus        (bus),
    .busy       (busy),
    .sr_pc      (sr_pc),
    .overflow   (overflow),
    .beats_sent (beats_sent)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Reference state
  logic [31:0] fifo_q[$];
  logic [31:0] pushed_q[$];
  int          exp_n;
  int          beat_idx;
  int          pops;
  int          push_left;
  int          push_pct;
  int          ready_mode;
  bit          exp_test;
  bit          sb_en;
  bit          chk_last;
  bit          saw_last;
  bit          prev_stall;
  logic [31:0] prev_data;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // k-th ramp beat: samples 2k and 2k+1, modulo 2^16
  function automatic logic [31:0] ramp_word(input int k);
    logic [15:0] lo;
    logic [15:0] hi;
    lo = 16'((2 * k) % 65536);
    hi = 16'((2 * k + 1) % 65536);
    return {hi, lo};
  endfunction

  task automatic drive_fifo();
    bus.fifo_valid = (fifo_q.size() != 0);
    bus.fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
  endtask

  // One clock: sample at negedge, advance FIFO model after posedge.
  task automatic tick();
    logic        rd;
    logic        vld;
    logic        hs;
    logic [31:0] exp_w;
    logic [31:0] w;
    @(negedge ACLK);
    rd  = bus.fifo_rd_en;
    vld = bus.fifo_valid;
    hs  = bus.m_axis_tvalid & bus.m_axis_tready;
    if (prev_stall) begin
      check_eq("stall_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
      check_eq("stall_tdata", 64'(bus.m_axis_tdata), 64'(prev_data));
    end
    if (sb_en && exp_test && vld) check_eq("test_discard", 64'(rd), 64'd1);
    if (sb_en && hs) begin
      if (exp_test) begin
        exp_w = ramp_word(beat_idx);
      end else begin
        check_eq("beat_src_avail", 64'(pushed_q.size() > beat_idx), 64'd1);
        exp_w = (pushed_q.size() > beat_idx) ? pushed_q[beat_idx] : 32'h0;
      end
      check_eq("beat_data", 64'(bus.m_axis_tdata), 64'(exp_w));
      if (chk_last) check_eq("beat_last", 64'(bus.m_axis_tlast), 64'(beat_idx == exp_n - 1));
      if (bus.m_axis_tlast) begin
        saw_last = 1'b1;
        if (!exp_test && chk_last) begin
          check_eq("pops_at_last", 64'(pops), 64'(exp_n));
          check_eq("no_pop_at_last", 64'(rd), 64'd0);
        end
      end
      beat_idx++;
    end
    prev_stall = bus.m_axis_tvalid & ~bus.m_axis_tready;
    prev_data  = bus.m_axis_tdata;
    @(posedge ACLK);
    #1;
    if (rd && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    if (push_left > 0 && int'($urandom_range(0, 99)) < push_pct) begin
      w = $urandom;
      fifo_q.push_back(w);
      if (!exp_test) pushed_q.push_back(w);
      push_left--;
    end
    case (ready_mode)
      0:       bus.m_axis_tready = 1'b1;
      1:       bus.m_axis_tready = ~bus.m_axis_tready;
      2:       bus.m_axis_tready = 1'($urandom_range(0, 1));
      default: bus.m_axis_tready = 1'b0;
    endcase
    drive_fifo();
  endtask

  task automatic sb_setup(input int n, input bit tm, input int rmode, input int ppct);
    sb_en     = 1'b0;
    push_left = 0;
    for (int i = 0; i < 20 && fifo_q.size() != 0; i++) tick();
    check_eq("pre_drain", 64'(fifo_q.size()), 64'd0);
    pushed_q.delete();
    exp_n      = n;
    exp_test   = tm;
    beat_idx   = 0;
    pops       = 0;
    saw_last   = 1'b0;
    chk_last   = 1'b1;
    ready_mode = rmode;
    push_pct   = ppct;
    push_left  = tm ? 4 : n + 1;
    sb_en      = 1'b1;
    test       = tm;
    dsize      = 32'(n);
    trig_mode  = 1'b0;
  endtask

  task automatic wait_last();
    for (int c = 0; c < 400 && !saw_last; c++) tick();
  endtask

  task automatic finish_checks(input int n);
    check_eq("end_saw_last", 64'(saw_last), 64'd1);
    check_eq("end_beat_count", 64'(beat_idx), 64'(n));
    check_eq("end_busy", 64'(busy), 64'd0);
    check_eq("end_sr_pc", 64'(sr_pc), 64'd1);
    check_eq("end_beats_sent", 64'(beats_sent), 64'(n));
    check_eq("end_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
  endtask

  task automatic run_capture(input int n, input bit tm, input int rmode, input int ppct);
    sb_setup(n, tm, rmode, ppct);
    start = 1'b1;
    tick();
    start = 1'b0;
    // Late config changes must be ignored until the next start.
    test  = ~test;
    dsize = 32'd1;
    wait_last();
    finish_checks(n);
  endtask

  task automatic check_reset_state(input string pfx);
    check_eq({pfx, "_tvalid"}, 64'(bus.m_axis_tvalid), 64'd0);
    check_eq({pfx, "_tlast"}, 64'(bus.m_axis_tlast), 64'd0);
    check_eq({pfx, "_tdata"}, 64'(bus.m_axis_tdata), 64'd0);
    check_eq({pfx, "_tkeep"}, 64'(bus.m_axis_tkeep), 64'hF);
    check_eq({pfx, "_busy"}, 64'(busy), 64'd0);
    check_eq({pfx, "_sr_pc"}, 64'(sr_pc), 64'd0);
    check_eq({pfx, "_overflow"}, 64'(overflow), 64'd0);
    check_eq({pfx, "_beats"}, 64'(beats_sent), 64'd0);
  endtask

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vcnt;
    n_total = 0;
    n_bad = 0;
    ARESETN = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    test = 1'b0;
    trig_mode = 1'b0;
    trig_in = 1'b0;
    dsize = 32'd0;
    bus.m_axis_tready = 1'b0;
    bus.fifo_full = 1'b0;
    bus.fifo_valid = 1'b0;
    bus.fifo_dout = 32'h0;
    ready_mode = 0;
    sb_en = 1'b0;
    push_left = 0;
    push_pct = 0;
    prev_stall = 1'b0;
    prev_data = 32'h0;
    repeat (3) @(posedge ACLK);
    #1;
    check_reset_state("rst");
    ARESETN = 1'b1;
    tick();

    // Normal capture, 4 beats, words A..E offered
    run_capture(4, 1'b0, 0, 100);
    // Backpressure with tready toggling
    run_capture(3, 1'b0, 1, 100);
    // Test ramp
    run_capture(3, 1'b1, 0, 100);

    // Trigger: held high at start must not fire; a later rising edge does
    sb_setup(2, 1'b1, 0, 0);
    trig_in = 1'b1;
    tick();
    tick();
    trig_mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    trig_mode = 1'b0;
    repeat (5) tick();
    check_eq("trig_high_no_beat", 64'(bus.m_axis_tvalid), 64'd0);
    check_eq("trig_wait_busy", 64'(busy), 64'd1);
    trig_in = 1'b0;
    tick();
    trig_in = 1'b1;
    tick();
    check_eq("trig_edge_lat0", 64'(bus.m_axis_tvalid), 64'd0);
    tick();
    check_eq("trig_edge_lat1", 64'(bus.m_axis_tvalid), 64'd1);
    wait_last();
    finish_checks(2);

    // Abort while beat 2 stalls
    sb_setup(10, 1'b1, 0, 0);
    chk_last = 1'b0;
    push_left = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 20 && beat_idx < 1; c++) tick();
    ready_mode = 3;
    bus.m_axis_tready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_tvalid_held", 64'(bus.m_axis_tvalid), 64'd1);
    check_eq("abort_tlast_forced", 64'(bus.m_axis_tlast), 64'd1);
    check_eq("abort_tdata_held", 64'(bus.m_axis_tdata), 64'(ramp_word(1)));
    check_eq("abort_busy", 64'(busy), 64'd1);
    tick();
    bus.m_axis_tready = 1'b1;
    ready_mode = 0;
    tick();
    check_eq("abort_idle_busy", 64'(busy), 64'd0);
    check_eq("abort_sr_pc", 64'(sr_pc), 64'd0);
    check_eq("abort_beats", 64'(beats_sent), 64'd2);
    check_eq("abort_tvalid_drop", 64'(bus.m_axis_tvalid), 64'd0);
    check_eq("abort_beat_idx", 64'(beat_idx), 64'd2);

    // dsize = 0
    sb_setup(0, 1'b0, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("dsize0_pc", 64'(sr_pc), 64'd1);
    check_eq("dsize0_busy", 64'(busy), 64'd0);
    check_eq("dsize0_beats", 64'(beats_sent), 64'd0);
    vcnt = 0;
    repeat (4) begin
      tick();
      if (bus.m_axis_tvalid) vcnt++;
    end
    check_eq("dsize0_novalid", 64'(vcnt), 64'd0);

    // start and abort together in DONE: abort wins
    start = 1'b1;
    abort = 1'b1;
    dsize = 32'd5;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_eq("start_abort_busy", 64'(busy), 64'd0);
    check_eq("start_abort_pc_kept", 64'(sr_pc), 64'd1);

    // Overflow sticky, cleared by next start
    sb_setup(6, 1'b0, 2, 60);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    bus.fifo_full = 1'b1;
    tick();
    bus.fifo_full = 1'b0;
    check_eq("ovf_set", 64'(overflow), 64'd1);
    wait_last();
    finish_checks(6);
    check_eq("ovf_sticky", 64'(overflow), 64'd1);
    sb_setup(3, 1'b1, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("ovf_cleared", 64'(overflow), 64'd0);
    wait_last();
    finish_checks(3);

    // Randomized captures
    for (int r = 0; r < 6; r++) begin
      run_capture(int'($urandom_range(1, 12)), 1'($urandom_range(0, 1)), 2,
                  int'($urandom_range(30, 100)));
    end

    // Asynchronous reset mid-capture
    sb_setup(8, 1'b1, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check_eq("rst_pre_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
    ARESETN = 1'b0;
    #1;
    check_reset_state("midrst");
    sb_en = 1'b0;
    prev_stall = 1'b0;
    tick();
    ARESETN = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
